alu_share_arb: RTL

Round-robin arbiter and sequencer that shares one combinational ALU (5-bit `sel`, 32-bit `data1`/`data2`/`result`) between `NUM_REQ` requesters in the RISC-V pipeline, such as the execute stage and the branch/address unit.
- Each requester issues an operation over a valid/ready request channel.
- The block registers the operands, drives the ALU for one cycle, captures the result, and returns it on a per-requester valid/ready response channel.
- Illegal opcodes are flagged rather than silently computed.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_share_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU sharing arbiter.
// Opcode list, legality bound and FSM state encoding.
package alu_pkg;

   localparam int ALU_OP_MAX = 9;

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_SUB  = 5'd1,
      OP_AND  = 5'd2,
      OP_OR   = 5'd3,
      OP_XOR  = 5'd4,
      OP_SLL1 = 5'd5,
      OP_SRL1 = 5'd6,
      OP_SRA1 = 5'd7,
      OP_GT   = 5'd8,
      OP_LT   = 5'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr, wrapping, for the first request.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   // first set request at or after ptr, wrapping around
   always_comb begin
      int  j;
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external ALU between NUM_REQ requesters.
// Accept -> drive ALU one cycle -> hold response until consumed.
module alu_share_arb
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int SEL_W   = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
   input  logic [NUM_REQ*DATA_W-1:0]  req_a,
   input  logic [NUM_REQ*DATA_W-1:0]  req_b,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [DATA_W-1:0]          rsp_data,
   output logic                       rsp_err,
   output logic [SEL_W-1:0]           alu_sel,
   output logic [DATA_W-1:0]          alu_data1,
   output logic [DATA_W-1:0]          alu_data2,
   input  logic [DATA_W-1:0]          alu_result,
   output logic                       busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [SEL_W-1:0]    op_sel_q, op_sel_d;
   logic [DATA_W-1:0]   op_a_q, op_a_d;
   logic [DATA_W-1:0]   op_b_q, op_b_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0]  gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic                illegal;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign illegal   = op_sel_q > SEL_W'(ALU_OP_MAX);
   assign alu_sel   = op_sel_q;
   assign alu_data1 = op_a_q;
   assign alu_data2 = op_b_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != ST_IDLE);

   // handshake outputs: grant only in IDLE, response only to owner
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state_q == ST_IDLE) req_ready = gnt;
      if (state_q == ST_RESP) rsp_valid[owner_q] = 1'b1;
   end

   // next-state and datapath register updates
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      op_sel_d   = op_sel_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               op_sel_d = req_sel[int'(gnt_idx)*SEL_W +: SEL_W];
               op_a_d   = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
               op_b_d   = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
               owner_d  = gnt_idx;
               if (gnt_idx == IDX_W'(NUM_REQ-1)) rr_ptr_d = '0;
               else rr_ptr_d = gnt_idx + 1'b1;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_err_d  = illegal;
            rsp_data_d = illegal ? '0 : alu_result;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready[owner_q]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         op_sel_q   <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         op_sel_q   <= op_sel_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

endmodule
